// File: rtl/riscuinho_pkg.sv
// Shared types for the program memory controller: loader state encoding and byte width.
package riscuinho_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } pgm_state_e;
endpackage

// File: rtl/pgm_word_assembler.sv
// Packs a little-endian byte stream into STEP-byte words, zero-padding unfilled lanes.
// PGM_CHECKSUM_EN adds a running 8-bit image checksum compared against the value sent with pgm_last.
module pgm_word_assembler
  import riscuinho_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     wr,
  input  logic                     accept,
  input  logic [BYTE_W-1:0]        byte_in,
  input  logic                     last_in,
`ifdef PGM_CHECKSUM_EN
  input  logic [BYTE_W-1:0]        chk_in,
  output logic                     chk_ok,
`endif
  output logic [STEP*BYTE_W-1:0]   word,
  output logic                     word_full,
  output logic                     last_q
);
  localparam int IW = (STEP > 1) ? $clog2(STEP) : 1;

  logic [IW-1:0]                 idx_q;
  logic [STEP-1:0][BYTE_W-1:0]   lanes_q;
  logic                          clr;

  // Lanes restart both on a new image and after each committed word.
  assign clr       = start | wr;
  assign word      = lanes_q;
  assign word_full = accept & (last_in | (idx_q == IW'(STEP-1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      lanes_q <= '0;
      last_q  <= 1'b0;
    end else if (clr) begin
      idx_q   <= '0;
      lanes_q <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      idx_q <= idx_q + 1'b1;
      for (int i = 0; i < STEP; i++)
        if (idx_q == IW'(i)) lanes_q[i] <= byte_in;
      if (last_in) last_q <= 1'b1;
    end
  end

`ifdef PGM_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, chk_q;

  // Sum spans the whole image, so it only restarts on a new load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      chk_q <= '0;
    end else if (start) begin
      sum_q <= '0;
      chk_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + byte_in;
      if (last_in) chk_q <= chk_in;
    end
  end

  assign chk_ok = (sum_q == chk_q);
`endif
endmodule

// File: rtl/program_memory_ctrl.sv
// Instruction memory with a registered fetch port and a byte-serial program loader.
// Define PGM_CHECKSUM_EN to add the pgm_checksum input and checksum-based load failure.
module program_memory_ctrl
  import riscuinho_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 20,
  parameter int STEP             = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_req,
  input  logic [INSTR_ADDR_WIDTH-1:0]   pc,
  output logic [STEP*BYTE_W-1:0]        instr,
  output logic                          instr_valid,
  output logic                          fetch_busy,
  input  logic                          pgm_start,
  input  logic [INSTR_ADDR_WIDTH-1:0]   pgm_base,
  input  logic                          pgm_byte_valid,
  input  logic [BYTE_W-1:0]             pgm_byte,
  input  logic                          pgm_last,
`ifdef PGM_CHECKSUM_EN
  input  logic [BYTE_W-1:0]             pgm_checksum,
`endif
  output logic                          pgm_ready,
  output logic [INSTR_ADDR_WIDTH:0]     pgm_count,
  output logic                          pgm_done,
  output logic                          pgm_error
);
  localparam int SIZE = 2**INSTR_ADDR_WIDTH;
  localparam int WW   = STEP*BYTE_W;

  pgm_state_e                    state_q, state_d;
  logic [INSTR_ADDR_WIDTH-1:0]   addr_q;
  logic [INSTR_ADDR_WIDTH:0]     count_q;
  logic [WW-1:0]                 mem [SIZE];
  logic [WW-1:0]                 word;
  logic                          loader_idle, start, accept, wr;
  logic                          word_full, last_q, chk_ok;

  assign loader_idle = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
  assign start       = pgm_start & loader_idle;
  assign pgm_ready   = (state_q == LOAD);
  assign accept      = pgm_ready & pgm_byte_valid;
  assign wr          = (state_q == WRITE);
  assign fetch_busy  = ~loader_idle;
  assign pgm_done    = (state_q == DONE);
  assign pgm_error   = (state_q == ERROR);
  assign pgm_count   = count_q;

  pgm_word_assembler #(.STEP(STEP)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wr        (wr),
    .accept    (accept),
    .byte_in   (pgm_byte),
    .last_in   (pgm_last),
`ifdef PGM_CHECKSUM_EN
    .chk_in    (pgm_checksum),
    .chk_ok    (chk_ok),
`endif
    .word      (word),
    .word_full (word_full),
    .last_q    (last_q)
  );

`ifndef PGM_CHECKSUM_EN
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: if (pgm_start) state_d = LOAD;
      LOAD:              if (word_full) state_d = WRITE;
      WRITE: begin
        if (last_q)       state_d = chk_ok ? DONE : ERROR;
        else if (&addr_q) state_d = ERROR;  // top of memory reached, no wrap
        else              state_d = LOAD;
      end
      default:           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= pgm_base;
        count_q <= '0;
      end else if (wr) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[addr_q] <= word;
  end

  // A load request takes priority over a same-cycle fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_req & loader_idle & ~pgm_start;
      if (fetch_req && loader_idle && !pgm_start) instr <= mem[pc];
    end
  end
endmodule
